approx_adder_pipe: RTL

- Parametrised, pipelined successor to the team's fixed 2-bit approximate adders.
- Adds two WIDTH-bit operands and returns a WIDTH+1-bit sum. The approximation mode is selected at runtime per transaction: exact, lower-part-OR (LOA) or lower-part-truncate, applied to the APPROX_LSB low bits.
- Uses a valid/ready pipeline and an on-line error monitor that compares each result against the exact sum and accumulates statistics against the error threshold ET.
- Sits between operand producers and result consumers in approximate-datapath test harnesses.

---
 rtl/approx_pkg.sv | 19 +
 rtl/approx_add_core.sv | 51 +++++
 rtl/approx_adder_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/approx_pkg.sv
// Shared types and helpers for the approximate adder pipeline.
package approx_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_LOA   = 2'd1,
    MODE_TRUNC = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Wide enough for any practical WIDTH+1 result; callers slice the low bits.
  localparam int ABS_W = 64;

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] x,
                                                input logic [ABS_W-1:0] y);
    return (x > y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/approx_add_core.sv
// Combinational WIDTH-bit adder with exact / lower-part-OR / lower-part-truncate modes.
// The APPROX_LSB low bits are approximated; the upper part adds with carry-in 0.
module approx_add_core
  import approx_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int APPROX_LSB = 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  mode_e            i_mode,
  output logic [WIDTH:0]   o_sum
);

  logic [WIDTH:0] w_exact;
  assign w_exact = {1'b0, i_a} + {1'b0, i_b};

  generate
    if (WIDTH < 1 || APPROX_LSB < 0 || APPROX_LSB > WIDTH) begin : g_bad_param
      $error("approx_add_core: WIDTH must be >= 1 and APPROX_LSB in 0..WIDTH");
    end

    if (APPROX_LSB == 0) begin : g_exact_only
      logic w_unused_mode;
      assign w_unused_mode = ^i_mode;
      assign o_sum         = w_exact;
    end else begin : g_approx
      localparam int L = APPROX_LSB;
      logic [L-1:0]     w_lo_or;
      logic [WIDTH-L:0] w_hi;

      assign w_lo_or = i_a[L-1:0] | i_b[L-1:0];

      if (L == WIDTH) begin : g_no_upper
        assign w_hi = '0;
      end else begin : g_upper
        assign w_hi = {1'b0, i_a[WIDTH-1:L]} + {1'b0, i_b[WIDTH-1:L]};
      end

      // Reserved mode falls through to exact.
      always_comb begin
        case (i_mode)
          MODE_LOA:   o_sum = {w_hi, w_lo_or};
          MODE_TRUNC: o_sum = {w_hi, {L{1'b0}}};
          default:    o_sum = w_exact;
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage valid/ready approximate adder, 2-cycle latency, result held while out_ready is low.
// Error monitor (out_err, err_cnt, err_max) is built only with APPROX_ADDER_PIPE_ERR_MON_EN.
module approx_adder_pipe
  import approx_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int APPROX_LSB = 1,
  parameter int ET         = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH:0]   out_err,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   err_max
);

  logic             r_s1_vld;
  logic             r_s2_vld;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  mode_e            r_s1_mode;
  logic [WIDTH:0]   r_sum;
  logic [WIDTH:0]   w_approx;
  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             w_s2_load;

  assign w_s2_adv  = !r_s2_vld || out_ready;
  assign w_s1_adv  = !r_s1_vld || w_s2_adv;
  assign w_s2_load = w_s2_adv && r_s1_vld;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_vld;
  assign out_sum   = r_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_mode <= MODE_EXACT;
    end else if (w_s1_adv) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
        r_s1_mode <= mode_e'(in_mode);
      end
    end
  end

  approx_add_core #(.WIDTH(WIDTH), .APPROX_LSB(APPROX_LSB)) u_approx (
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .i_mode (r_s1_mode),
    .o_sum  (w_approx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_vld <= 1'b0;
      r_sum    <= '0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) r_sum <= w_approx;
    end
  end

`ifdef APPROX_ADDER_PIPE_ERR_MON_EN
  logic [WIDTH:0]   w_exact;
  logic [ABS_W-1:0] w_diff;
  logic             w_evt;
  logic [WIDTH:0]   r_err;
  logic [WIDTH:0]   r_max;
  logic [CNT_W-1:0] r_cnt;

  approx_add_core #(.WIDTH(WIDTH), .APPROX_LSB(APPROX_LSB)) u_exact (
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .i_mode (MODE_EXACT),
    .o_sum  (w_exact)
  );

  assign w_diff = abs_diff(ABS_W'(w_exact), ABS_W'(w_approx));
  assign w_evt  = w_diff > ABS_W'(ET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else if (w_s2_load) begin
      r_err <= w_diff[WIDTH:0];
    end
  end

  // Statistics follow S2 loads, so a stalled result is never recounted; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_max <= '0;
    end else if (stat_clr) begin
      r_cnt <= '0;
      r_max <= '0;
    end else if (w_s2_load) begin
      if (w_evt && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      if (w_diff[WIDTH:0] > r_max) r_max <= w_diff[WIDTH:0];
    end
  end

  assign out_err = r_err;
  assign err_cnt = r_cnt;
  assign err_max = r_max;
`else
  logic w_unused_clr;
  assign w_unused_clr = stat_clr;
  assign out_err      = '0;
  assign err_cnt      = '0;
  assign err_max      = '0;
`endif

endmodule
